csr_access_unit: RTL and testbench
==================================

Name: csr_access_unit

Overview:
- Requester side of the CSR register file's read/write port pair.
- Executes one Zicsr instruction per request: CSRRW, CSRRS, CSRRC and their immediate forms.
- Performs the read-modify-write against the CSR file, checks access legality, and returns the old CSR value for rd.
- On an illegal access, drives the register file's exception inputs (event/cause/pc/tval/priv mode) instead of writing.
- Sits between decode/execute and csr_regs.

Parameters:
- XLEN, pkg_parameters::XLEN (64): data width of CSRs, rs1 value and rd result.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  1  CSR instruction request valid
- req_ready_o  out  1  unit can accept a request
- req_funct3_i  in  3  instruction funct3
- req_csr_addr_i  in  12  CSR address
- req_rs1_val_i  in  XLEN  rs1 register value
- req_rs1_idx_i  in  5  rs1 index, which doubles as uimm for the immediate forms
- req_rd_idx_i  in  5  destination register index
- req_pc_i  in  XLEN  PC of the instruction
- req_instr_i  in  32  raw instruction bits
- priv_mode_i  in  2  current privilege mode
- resp_valid_o  out  1  result valid
- resp_ready_i  in  1  result consumed
- resp_rd_idx_o  out  5  destination index
- resp_rd_data_o  out  XLEN  old CSR value
- resp_rd_we_o  out  1  write rd
- resp_trap_o  out  1  instruction trapped
- csr_raddr_o  out  12  CSR read address
- csr_rdata_i  in  XLEN  CSR read data (combinational from csr_regs)
- csr_waddr_o  out  12  CSR write address
- csr_wdata_o  out  XLEN  CSR write data
- csr_web_o  out  1  CSR write enable, 1 = write
- exc_event_o  out  1  exception pulse
- exc_cause_o  out  exception_code_e  exception cause
- exc_pc_o  out  XLEN  faulting PC
- exc_tval_o  out  XLEN  trap value
- exc_priv_mode_o  out  2  privilege mode at the trap

Behaviour:
Reset and latching:
- Reset is synchronous and active-high. It forces state IDLE, and every output is 0 except req_ready_o=1.
- Reset in any state aborts the operation with no csr_web_o or exc_event_o pulse afterwards.
- In IDLE, req_ready_o=1. On the req_valid_i & req_ready_o cycle, all request fields are latched and the FSM moves to READ.
- req_ready_o is 0 in every other state.

READ state (1 cycle):
- csr_raddr_o = latched address; the unit samples csr_rdata_i into old_val.
- Operand: register forms (funct3 001/010/011) use rs1_val; immediate forms (101/110/111) use uimm zero-extended to XLEN.
- write_intent: always 1 for RW/RWI. For RS/RC/RSI/RCI it is 1 only if rs1_idx/uimm != 0.
- Illegal if any of the following holds:
  - funct3 is 000 or 100
  - write_intent and addr[11:10]==2'b11 (read-only CSR)
  - priv_mode_i < addr[9:8]
- Next state: TRAP if illegal; else WRITE if write_intent; else RESP.

WRITE state (1 cycle):
- csr_web_o=1, csr_waddr_o=address.
- csr_wdata_o: RW = operand; RS = old_val | operand; RC = old_val & ~operand.
- Then RESP.

TRAP state (1 cycle):
- exc_event_o=1, exc_cause_o=ILLEGAL_INSTRUCTION (2).
- exc_pc_o=req_pc, exc_tval_o=instr zero-extended, exc_priv_mode_o=priv_mode_i.
- csr_web_o=0. Then RESP with the trap flag set.

RESP state:
- resp_valid_o=1, resp_rd_idx_o=rd_idx, resp_rd_data_o=old_val.
- resp_rd_we_o = (rd_idx != 0) & ~trap; resp_trap_o = trap.
- Outputs hold stable until resp_ready_i; then IDLE.
- A new request cannot be accepted in the same cycle as response completion.

Pulses and latency:
- csr_web_o and exc_event_o are single-cycle pulses, never asserted together.
- Latency from the accept cycle T: resp_valid at T+3 with a write, T+2 without, T+3 on a trap.
- Throughput is at most 1 instruction per 3–4 cycles.
- exc_event_o and csr_web_o are not asserted in the same cycle by construction, so an exception never coincides with a write.

Decomposition:
- pkg_csr gains:
  - csr_funct3_e (CSRRW=3'b001 … CSRRCI=3'b111)
  - CSR_ADDR_W=12
  - ILLEGAL_INSTRUCTION in exception_code_e, if absent
- The FSM state enum stays local to the module.
- One natural sub-module: csr_alu. It is combinational, maps (funct3, old_val, operand) to wdata, and is reusable by a future pipelined CSR path.

Test Plan:
- CSRRW 0x340, rs1_val=0xDEADBEEF, rd=5, rdata=0 -> T+2: web=1, waddr=0x340, wdata=0xDEADBEEF; T+3: resp rd_data=0, rd_we=1.
- CSRRS rs1_idx=0 on 0xB00, rdata=0x1234 -> no web pulse; T+2 resp rd_data=0x1234, rd_we=1.
- CSRRC 0x340, rs1_val=0xF0, old=0xFF -> wdata=0x0F. CSRRSI uimm=0x5, old=0x8 -> wdata=0xD.
- CSRRW 0xF11 (read-only) with instr=0xF1101073 and pc=0x80 -> T+2: exc_event=1, cause=2, pc=0x80, tval=0xF1101073; no web; resp_trap=1, rd_we=0. funct3=100 traps identically.
- priv_mode=U (00), CSRRS x0 on 0x300 -> privilege trap, cause=2. Same access with priv_mode=M (11) -> legal, no write.
- Backpressure and reset:
  - resp_ready_i low for 4 cycles -> resp fields stable, req_ready_o=0.
  - rst asserted in READ with a write pending -> no web pulse in any later cycle; next cycle idle outputs, req_ready_o=1.

Source files
------------

// File: rtl/csr_access_unit_pkg.sv
// Shared types for the Zicsr requester: funct3 encodings, exception codes and
// CSR address-field helpers.
package csr_access_unit_pkg;

  localparam int CSR_XLEN   = 64;
  localparam int CSR_ADDR_W = 12;

  typedef enum logic [2:0] {
    CSRRW  = 3'b001,
    CSRRS  = 3'b010,
    CSRRC  = 3'b011,
    CSRRWI = 3'b101,
    CSRRSI = 3'b110,
    CSRRCI = 3'b111
  } csr_funct3_e;

  typedef enum logic [4:0] {
    INSTR_ADDR_MISALIGNED = 5'd0,
    INSTR_ACCESS_FAULT    = 5'd1,
    ILLEGAL_INSTRUCTION   = 5'd2,
    BREAKPOINT            = 5'd3
  } exception_code_e;

  // Address bits [11:10] == 2'b11 mark the read-only CSR space.
  function automatic logic csr_is_read_only(input logic [CSR_ADDR_W-1:0] addr);
    return (addr[11:10] == 2'b11);
  endfunction

  function automatic logic [1:0] csr_min_priv(input logic [CSR_ADDR_W-1:0] addr);
    return addr[9:8];
  endfunction

endpackage

// File: rtl/csr_access_unit_csr_alu.sv
// Combinational read-modify-write datapath: maps (funct3, old value, operand)
// to the value written back to the CSR.
module csr_alu
  import csr_access_unit_pkg::*;
#(
  parameter int XLEN = CSR_XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] wdata
);

  // Select write / set-bits / clear-bits behaviour
  always_comb begin
    wdata = old_val;
    case (funct3)
      CSRRW, CSRRWI: wdata = operand;
      CSRRS, CSRRSI: wdata = old_val | operand;
      CSRRC, CSRRCI: wdata = old_val & ~operand;
      default:       wdata = old_val;
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// Requester side of the CSR file port pair: runs one Zicsr instruction per
// request as a read, optional write or trap, then a held response.
module csr_access_unit
  import csr_access_unit_pkg::*;
#(
  parameter int XLEN = CSR_XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_funct3_i,
  input  logic [CSR_ADDR_W-1:0] req_csr_addr_i,
  input  logic [XLEN-1:0]       req_rs1_val_i,
  input  logic [4:0]            req_rs1_idx_i,
  input  logic [4:0]            req_rd_idx_i,
  input  logic [XLEN-1:0]       req_pc_i,
  input  logic [31:0]           req_instr_i,
  input  logic [1:0]            priv_mode_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [4:0]            resp_rd_idx_o,
  output logic [XLEN-1:0]       resp_rd_data_o,
  output logic                  resp_rd_we_o,
  output logic                  resp_trap_o,
  output logic [CSR_ADDR_W-1:0] csr_raddr_o,
  input  logic [XLEN-1:0]       csr_rdata_i,
  output logic [CSR_ADDR_W-1:0] csr_waddr_o,
  output logic [XLEN-1:0]       csr_wdata_o,
  output logic                  csr_web_o,
  output logic                  exc_event_o,
  output exception_code_e       exc_cause_o,
  output logic [XLEN-1:0]       exc_pc_o,
  output logic [XLEN-1:0]       exc_tval_o,
  output logic [1:0]            exc_priv_mode_o
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, TRAP, RESP} state_e;

  state_e                  state_r;
  logic [2:0]              funct3_r;
  logic [CSR_ADDR_W-1:0]   addr_r;
  logic [XLEN-1:0]         rs1_val_r;
  logic [4:0]              rs1_idx_r;
  logic [4:0]              rd_idx_r;
  logic [XLEN-1:0]         pc_r;
  logic [31:0]             instr_r;
  logic [XLEN-1:0]         old_val_r;

  logic [XLEN-1:0]         operand_s;
  logic [XLEN-1:0]         alu_wdata_s;
  logic                    write_intent_s;
  logic                    illegal_s;

  // Operand selection, write intent and legality of the latched instruction
  always_comb begin
    operand_s      = '0;
    write_intent_s = 1'b0;
    illegal_s      = 1'b0;
    if (funct3_r[2]) begin
      operand_s = XLEN'(rs1_idx_r);
    end else begin
      operand_s = rs1_val_r;
    end
    // RW forms always write; set/clear with a zero source are pure reads
    if (funct3_r[1:0] == 2'b01) begin
      write_intent_s = 1'b1;
    end else begin
      write_intent_s = (rs1_idx_r != 5'd0);
    end
    if ((funct3_r[1:0] == 2'b00) ||
        (write_intent_s && csr_is_read_only(addr_r)) ||
        (priv_mode_i < csr_min_priv(addr_r))) begin
      illegal_s = 1'b1;
    end else begin
      illegal_s = 1'b0;
    end
  end

  csr_alu #(.XLEN(XLEN)) u_csr_alu (
    .funct3  (funct3_r),
    .old_val (csr_rdata_i),
    .operand (operand_s),
    .wdata   (alu_wdata_s)
  );

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      req_ready_o     <= 1'b1;
      funct3_r        <= 3'd0;
      addr_r          <= '0;
      rs1_val_r       <= '0;
      rs1_idx_r       <= 5'd0;
      rd_idx_r        <= 5'd0;
      pc_r            <= '0;
      instr_r         <= 32'd0;
      old_val_r       <= '0;
      resp_valid_o    <= 1'b0;
      resp_rd_idx_o   <= 5'd0;
      resp_rd_data_o  <= '0;
      resp_rd_we_o    <= 1'b0;
      resp_trap_o     <= 1'b0;
      csr_raddr_o     <= '0;
      csr_waddr_o     <= '0;
      csr_wdata_o     <= '0;
      csr_web_o       <= 1'b0;
      exc_event_o     <= 1'b0;
      exc_cause_o     <= INSTR_ADDR_MISALIGNED;
      exc_pc_o        <= '0;
      exc_tval_o      <= '0;
      exc_priv_mode_o <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            funct3_r    <= req_funct3_i;
            addr_r      <= req_csr_addr_i;
            rs1_val_r   <= req_rs1_val_i;
            rs1_idx_r   <= req_rs1_idx_i;
            rd_idx_r    <= req_rd_idx_i;
            pc_r        <= req_pc_i;
            instr_r     <= req_instr_i;
            csr_raddr_o <= req_csr_addr_i;
            req_ready_o <= 1'b0;
            state_r     <= READ;
          end
        end
        READ: begin
          old_val_r   <= csr_rdata_i;
          csr_raddr_o <= '0;
          if (illegal_s) begin
            exc_event_o     <= 1'b1;
            exc_cause_o     <= ILLEGAL_INSTRUCTION;
            exc_pc_o        <= pc_r;
            exc_tval_o      <= XLEN'(instr_r);
            exc_priv_mode_o <= priv_mode_i;
            state_r         <= TRAP;
          end else if (write_intent_s) begin
            csr_web_o   <= 1'b1;
            csr_waddr_o <= addr_r;
            csr_wdata_o <= alu_wdata_s;
            state_r     <= WRITE;
          end else begin
            resp_valid_o   <= 1'b1;
            resp_rd_idx_o  <= rd_idx_r;
            resp_rd_data_o <= csr_rdata_i;
            resp_rd_we_o   <= (rd_idx_r != 5'd0);
            resp_trap_o    <= 1'b0;
            state_r        <= RESP;
          end
        end
        WRITE: begin
          csr_web_o      <= 1'b0;
          csr_waddr_o    <= '0;
          csr_wdata_o    <= '0;
          resp_valid_o   <= 1'b1;
          resp_rd_idx_o  <= rd_idx_r;
          resp_rd_data_o <= old_val_r;
          resp_rd_we_o   <= (rd_idx_r != 5'd0);
          resp_trap_o    <= 1'b0;
          state_r        <= RESP;
        end
        TRAP: begin
          exc_event_o     <= 1'b0;
          exc_cause_o     <= INSTR_ADDR_MISALIGNED;
          exc_pc_o        <= '0;
          exc_tval_o      <= '0;
          exc_priv_mode_o <= 2'd0;
          resp_valid_o    <= 1'b1;
          resp_rd_idx_o   <= rd_idx_r;
          resp_rd_data_o  <= old_val_r;
          resp_rd_we_o    <= 1'b0;
          resp_trap_o     <= 1'b1;
          state_r         <= RESP;
        end
        RESP: begin
          // Ready rises only in the cycle after completion
          if (resp_ready_i) begin
            resp_valid_o   <= 1'b0;
            resp_rd_idx_o  <= 5'd0;
            resp_rd_data_o <= '0;
            resp_rd_we_o   <= 1'b0;
            resp_trap_o    <= 1'b0;
            req_ready_o    <= 1'b1;
            state_r        <= IDLE;
          end
        end
        default: begin
          req_ready_o <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed self-checking bench for csr_access_unit with a behavioural CSR file
// and a transaction-level model of the expected per-cycle behaviour.
module tb_csr_access_unit;
  import csr_access_unit_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid_i;
  logic            req_ready_o;
  logic [2:0]      req_funct3_i;
  logic [11:0]     req_csr_addr_i;
  logic [63:0]     req_rs1_val_i;
  logic [4:0]      req_rs1_idx_i;
  logic [4:0]      req_rd_idx_i;
  logic [63:0]     req_pc_i;
  logic [31:0]     req_instr_i;
  logic [1:0]      priv_mode_i;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [4:0]      resp_rd_idx_o;
  logic [63:0]     resp_rd_data_o;
  logic            resp_rd_we_o;
  logic            resp_trap_o;
  logic [11:0]     csr_raddr_o;
  logic [63:0]     csr_rdata_i;
  logic [11:0]     csr_waddr_o;
  logic [63:0]     csr_wdata_o;
  logic            csr_web_o;
  logic            exc_event_o;
  exception_code_e exc_cause_o;
  logic [63:0]     exc_pc_o;
  logic [63:0]     exc_tval_o;
  logic [1:0]      exc_priv_mode_o;

  csr_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_funct3_i(req_funct3_i), .req_csr_addr_i(req_csr_addr_i),
    .req_rs1_val_i(req_rs1_val_i), .req_rs1_idx_i(req_rs1_idx_i),
    .req_rd_idx_i(req_rd_idx_i), .req_pc_i(req_pc_i), .req_instr_i(req_instr_i),
    .priv_mode_i(priv_mode_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rd_idx_o(resp_rd_idx_o), .resp_rd_data_o(resp_rd_data_o),
    .resp_rd_we_o(resp_rd_we_o), .resp_trap_o(resp_trap_o),
    .csr_raddr_o(csr_raddr_o), .csr_rdata_i(csr_rdata_i),
    .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o), .csr_web_o(csr_web_o),
    .exc_event_o(exc_event_o), .exc_cause_o(exc_cause_o), .exc_pc_o(exc_pc_o),
    .exc_tval_o(exc_tval_o), .exc_priv_mode_o(exc_priv_mode_o)
  );

  always #5 clk = ~clk;

  // Behavioural CSR file seen by the DUT
  logic [63:0] csr_mem [4096];
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [63:0] pl_val;
  assign csr_rdata_i = csr_mem[csr_raddr_o];
  always @(posedge clk) begin
    if (pl_en) csr_mem[pl_addr] <= pl_val;
    else if (csr_web_o) csr_mem[csr_waddr_o] <= csr_wdata_o;
  end

  // Bench-side reference copy of CSR contents
  logic [63:0] model_mem [int];

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [63:0] rs1_val;
    logic [4:0]  rs1_idx;
    logic [4:0]  rd;
    logic [63:0] pc;
    logic [1:0]  priv;
  } op_t;

  int n_cmp = 0;
  int n_err = 0;

  bit          obs_web, obs_exc, obs_resp, obs_trap, obs_rd_we;
  logic [63:0] obs_wdata, obs_rd_data, obs_pc, obs_tval;
  logic [4:0]  obs_cause;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag, input bit full);
    chk({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
    chk({tag, "_resp_valid"}, 64'(resp_valid_o), 64'd0);
    chk({tag, "_web"}, 64'(csr_web_o), 64'd0);
    chk({tag, "_exc_event"}, 64'(exc_event_o), 64'd0);
    if (full) begin
      chk({tag, "_rd_idx"}, 64'(resp_rd_idx_o), 64'd0);
      chk({tag, "_rd_data"}, resp_rd_data_o, 64'd0);
      chk({tag, "_rd_we"}, 64'(resp_rd_we_o), 64'd0);
      chk({tag, "_trap"}, 64'(resp_trap_o), 64'd0);
      chk({tag, "_raddr"}, 64'(csr_raddr_o), 64'd0);
      chk({tag, "_waddr"}, 64'(csr_waddr_o), 64'd0);
      chk({tag, "_wdata"}, csr_wdata_o, 64'd0);
      chk({tag, "_cause"}, 64'(exc_cause_o), 64'd0);
      chk({tag, "_exc_pc"}, exc_pc_o, 64'd0);
      chk({tag, "_tval"}, exc_tval_o, 64'd0);
      chk({tag, "_exc_priv"}, 64'(exc_priv_mode_o), 64'd0);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [63:0] v);
    pl_en = 1'b1; pl_addr = a; pl_val = v;
    @(posedge clk); @(negedge clk);
    pl_en = 1'b0;
    model_mem[int'(a)] = v;
  endtask

  // Issue one instruction and check every cycle until the response completes
  task automatic run_op(input string tag, input op_t op, input int hold, input bit do_reset);
    logic [31:0] instr;
    logic [63:0] old_v, opnd, wd;
    bit          wi, ill, done, hs;
    int          lat;
    instr = {op.addr, op.rs1_idx, op.f3, op.rd, 7'h73};
    old_v = model_mem.exists(int'(op.addr)) ? model_mem[int'(op.addr)] : 64'd0;
    opnd  = op.f3[2] ? 64'(op.rs1_idx) : op.rs1_val;
    wi    = (op.f3 == 3'b001) || (op.f3 == 3'b101) || (op.rs1_idx != 5'd0);
    ill   = (op.f3 == 3'b000) || (op.f3 == 3'b100) ||
            (wi && op.addr[11:10] == 2'b11) || (op.priv < op.addr[9:8]);
    if (op.f3 == 3'b001 || op.f3 == 3'b101) wd = opnd;
    else if (op.f3 == 3'b010 || op.f3 == 3'b110) wd = old_v | opnd;
    else wd = old_v & ~opnd;
    lat = (ill || wi) ? 3 : 2;
    obs_web = 0; obs_exc = 0; obs_resp = 0; obs_trap = 0; obs_rd_we = 0;
    obs_wdata = '0; obs_rd_data = '0; obs_pc = '0; obs_tval = '0; obs_cause = '0;

    check_idle({tag, "_pre"}, 1'b0);
    req_funct3_i = op.f3; req_csr_addr_i = op.addr; req_rs1_val_i = op.rs1_val;
    req_rs1_idx_i = op.rs1_idx; req_rd_idx_i = op.rd; req_pc_i = op.pc;
    req_instr_i = instr; priv_mode_i = op.priv; req_valid_i = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid_i = 1'b0;
    done = 0;
    for (int k = 1; k <= 40 && !done; k++) begin
      chk({tag, "_req_ready"}, 64'(req_ready_o), 64'd0);
      chk({tag, "_resp_valid"}, 64'(resp_valid_o), 64'(k >= lat));
      chk({tag, "_web"}, 64'(csr_web_o), 64'(!ill && wi && k == 2));
      chk({tag, "_exc_event"}, 64'(exc_event_o), 64'(ill && k == 2));
      if (k == 1) chk({tag, "_raddr"}, 64'(csr_raddr_o), 64'(op.addr));
      if (csr_web_o) begin
        obs_web = 1; obs_wdata = csr_wdata_o;
        chk({tag, "_waddr"}, 64'(csr_waddr_o), 64'(op.addr));
        chk({tag, "_wdata"}, csr_wdata_o, wd);
      end
      if (exc_event_o) begin
        obs_exc = 1; obs_cause = exc_cause_o; obs_pc = exc_pc_o; obs_tval = exc_tval_o;
        chk({tag, "_cause"}, 64'(exc_cause_o), 64'd2);
        chk({tag, "_exc_pc"}, exc_pc_o, op.pc);
        chk({tag, "_tval"}, exc_tval_o, 64'(instr));
        chk({tag, "_exc_priv"}, 64'(exc_priv_mode_o), 64'(op.priv));
      end
      if (resp_valid_o) begin
        if (!obs_resp) begin
          obs_resp = 1; obs_rd_data = resp_rd_data_o;
          obs_trap = resp_trap_o; obs_rd_we = resp_rd_we_o;
        end
        chk({tag, "_rd_idx"}, 64'(resp_rd_idx_o), 64'(op.rd));
        chk({tag, "_rd_data"}, resp_rd_data_o, old_v);
        chk({tag, "_rd_we"}, 64'(resp_rd_we_o), 64'(op.rd != 5'd0 && !ill));
        chk({tag, "_trap"}, 64'(resp_trap_o), 64'(ill));
      end
      if (do_reset && k == 1) begin
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check_idle({tag, "_after_rst"}, 1'b1);
        for (int j = 0; j < 6; j++) begin
          @(negedge clk);
          chk({tag, "_no_late_web"}, 64'(csr_web_o), 64'd0);
          chk({tag, "_no_late_exc"}, 64'(exc_event_o), 64'd0);
        end
        return;
      end
      resp_ready_i = (k >= lat + hold);
      hs = resp_ready_i && resp_valid_o;
      @(posedge clk); @(negedge clk);
      resp_ready_i = 1'b0;
      done = hs;
    end
    chk({tag, "_resp_done"}, 64'(done), 64'd1);
    check_idle({tag, "_post"}, 1'b0);
    if (!ill && wi) model_mem[int'(op.addr)] = wd;
  endtask

  op_t o;

  initial begin
    rst = 1'b1; req_valid_i = 1'b0; resp_ready_i = 1'b0; pl_en = 1'b0;
    pl_addr = '0; pl_val = '0; req_funct3_i = '0; req_csr_addr_i = '0;
    req_rs1_val_i = '0; req_rs1_idx_i = '0; req_rd_idx_i = '0; req_pc_i = '0;
    req_instr_i = '0; priv_mode_i = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset", 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check_idle("out_of_reset", 1'b1);

    preload(12'h340, 64'h0);
    preload(12'hB00, 64'h1234);
    preload(12'hF11, 64'h0);
    preload(12'h300, 64'h1800);
    preload(12'h341, 64'h77);

    o = '{3'b001, 12'h340, 64'hDEADBEEF, 5'd1, 5'd5, 64'h100, 2'b11};
    run_op("csrrw", o, 0, 1'b0);
    chk("csrrw_web_lit", 64'(obs_web), 64'd1);
    chk("csrrw_wdata_lit", obs_wdata, 64'hDEADBEEF);
    chk("csrrw_rd_data_lit", obs_rd_data, 64'h0);
    chk("csrrw_rd_we_lit", 64'(obs_rd_we), 64'd1);

    o = '{3'b010, 12'hB00, 64'hFFFF, 5'd0, 5'd7, 64'h104, 2'b11};
    run_op("csrrs_x0", o, 0, 1'b0);
    chk("csrrs_x0_web_lit", 64'(obs_web), 64'd0);
    chk("csrrs_x0_rd_data_lit", obs_rd_data, 64'h1234);

    preload(12'h340, 64'hFF);
    o = '{3'b011, 12'h340, 64'hF0, 5'd3, 5'd6, 64'h108, 2'b11};
    run_op("csrrc", o, 0, 1'b0);
    chk("csrrc_wdata_lit", obs_wdata, 64'h0F);

    preload(12'h340, 64'h8);
    o = '{3'b110, 12'h340, 64'hFFFF_FFFF, 5'd5, 5'd8, 64'h10C, 2'b11};
    run_op("csrrsi", o, 0, 1'b0);
    chk("csrrsi_wdata_lit", obs_wdata, 64'hD);

    o = '{3'b001, 12'hF11, 64'h55, 5'd0, 5'd0, 64'h80, 2'b11};
    run_op("ro_trap", o, 0, 1'b0);
    chk("ro_trap_exc_lit", 64'(obs_exc), 64'd1);
    chk("ro_trap_cause_lit", 64'(obs_cause), 64'd2);
    chk("ro_trap_pc_lit", obs_pc, 64'h80);
    chk("ro_trap_tval_lit", obs_tval, 64'hF1101073);
    chk("ro_trap_web_lit", 64'(obs_web), 64'd0);
    chk("ro_trap_flag_lit", 64'(obs_trap), 64'd1);
    chk("ro_trap_rd_we_lit", 64'(obs_rd_we), 64'd0);

    o = '{3'b100, 12'h340, 64'h1, 5'd1, 5'd4, 64'h90, 2'b11};
    run_op("f3_100", o, 0, 1'b0);
    chk("f3_100_cause_lit", 64'(obs_cause), 64'd2);
    chk("f3_100_web_lit", 64'(obs_web), 64'd0);

    o = '{3'b010, 12'h300, 64'h0, 5'd0, 5'd9, 64'hA0, 2'b00};
    run_op("priv_u", o, 0, 1'b0);
    chk("priv_u_exc_lit", 64'(obs_exc), 64'd1);
    chk("priv_u_cause_lit", 64'(obs_cause), 64'd2);

    o.priv = 2'b11;
    run_op("priv_m", o, 0, 1'b0);
    chk("priv_m_exc_lit", 64'(obs_exc), 64'd0);
    chk("priv_m_web_lit", 64'(obs_web), 64'd0);
    chk("priv_m_rd_data_lit", obs_rd_data, 64'h1800);

    o = '{3'b001, 12'h341, 64'hA5A5, 5'd2, 5'd10, 64'hB0, 2'b11};
    run_op("backpressure", o, 4, 1'b0);
    chk("backpressure_rd_data_lit", obs_rd_data, 64'h77);

    o = '{3'b001, 12'h341, 64'h1111, 5'd2, 5'd11, 64'hC0, 2'b11};
    run_op("rst_in_read", o, 0, 1'b1);

    o = '{3'b010, 12'h341, 64'h0, 5'd0, 5'd0, 64'hD0, 2'b11};
    run_op("after_rst", o, 0, 1'b0);
    chk("after_rst_unchanged_lit", obs_rd_data, 64'hA5A5);
    chk("after_rst_rd_we_lit", 64'(obs_rd_we), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
